// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the FSM state encodings, the supported opcodes, the alu_op codes
// and the packed control word produced by the output decoder.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write_uncond;
        logic       branch;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath-facing bundle of the multicycle control unit.
// slave  : the control unit (reads opcode/zero, drives the controls)
// master : the datapath / environment (drives opcode/zero)
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       zero;
    logic       pc_write;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state_o;

    modport master (
        output opcode, zero,
        input  pc_write, iord, ir_write, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, state_o
    );

    modport slave (
        input  opcode, zero,
        output pc_write, iord, ir_write, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, state_o
    );

endinterface

// File: rtl/mc_output_decode.sv
// Pure combinational Moore decode: FSM state -> control word.
// Ports: state (in), ctrl (out). Unlisted fields and illegal codes give 0.
module mc_output_decode
    import mips_mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write        = 1'b1;
                ctrl.alu_src_b       = 2'b01;
                ctrl.alu_op          = ALU_ADD;
                ctrl.pc_write_uncond = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_BEQEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.branch    = 1'b1;
            end
            S_JEX: begin
                ctrl.pc_src          = 2'b10;
                ctrl.pc_write_uncond = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit (Moore FSM).
// Ports: clk, rst (async, active low), bus (opcode/zero in, datapath
// controls and state_o out).
//
// state   | meaning
// FETCH   | read instruction, PC <= PC+4
// DECODE  | read registers, precompute branch target
// MEMADR  | lw/sw address = rs + imm
// MEMRD   | lw memory read
// MEMWB   | lw write-back to rt
// MEMWR   | sw memory write
// EXECUTE | R-type ALU operation
// ALUWB   | R-type write-back to rd
// BEQEX   | compare; PC <= target when zero
// ADDIEX  | addi rs + imm
// ADDIWB  | addi write-back to rt
// JEX     | jump
module multicycle_control
    import mips_mc_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.slave bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw/sw reach MEMADR, so anything not sw is treated as lw.
            S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_output_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    always_comb begin
        // branch is only set in BEQEX, so zero has no effect elsewhere.
        bus.pc_write   = ctrl.pc_write_uncond | (ctrl.branch & bus.zero);
        bus.iord       = ctrl.iord;
        bus.ir_write   = ctrl.ir_write;
        bus.mem_write  = ctrl.mem_write;
        bus.reg_write  = ctrl.reg_write;
        bus.reg_dst    = ctrl.reg_dst;
        bus.mem_to_reg = ctrl.mem_to_reg;
        bus.alu_src_a  = ctrl.alu_src_a;
        bus.alu_src_b  = ctrl.alu_src_b;
        bus.alu_op     = ctrl.alu_op;
        bus.pc_src     = ctrl.pc_src;
        bus.state_o    = state_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected
// (state, control word) pairs are queued when the opcode is driven and
// compared one per cycle at the falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] ctl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {pc_write, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
    //  alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0]}
    function automatic logic [13:0] exp_ctl(input logic [3:0] st, input logic z);
        case (st)
            4'd0:        return {1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'b01, 2'b00, 2'b00};
            4'd1:        return {7'b0, 1'b0, 2'b11, 2'b00, 2'b00};
            4'd2, 4'd9:  return {7'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            4'd3:        return {1'b0, 1'b1, 5'b0, 1'b0, 6'b0};
            4'd4:        return {4'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0};
            4'd5:        return {1'b0, 1'b1, 1'b0, 1'b1, 3'b0, 1'b0, 6'b0};
            4'd6:        return {7'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            4'd7:        return {4'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b0};
            4'd8:        return {z, 6'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            4'd10:       return {4'b0, 1'b1, 2'b00, 1'b0, 6'b0};
            4'd11:       return {1'b1, 6'b0, 1'b0, 2'b00, 2'b00, 2'b10};
            default:     return 14'b0;
        endcase
    endfunction

    function automatic logic [13:0] obs_ctl();
        return {bus.pc_write, bus.iord, bus.ir_write, bus.mem_write, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_src};
    endfunction

    task automatic push_st(input logic [3:0] st, input logic z);
        exp_t e;
        e.st  = st;
        e.ctl = exp_ctl(st, z);
        sb_q.push_back(e);
    endtask

    // Drive one instruction and queue its expected per-cycle trace, starting
    // with the FETCH cycle and ending before the next FETCH.
    task automatic drive_instr(input logic [5:0] op, input logic z);
        bus.opcode = op;
        bus.zero   = z;
        push_st(4'd0, z);
        push_st(4'd1, z);
        case (op)
            6'b100011: begin push_st(4'd2, z); push_st(4'd3, z); push_st(4'd4, z); end
            6'b101011: begin push_st(4'd2, z); push_st(4'd5, z); end
            6'b000000: begin push_st(4'd6, z); push_st(4'd7, z); end
            6'b001000: begin push_st(4'd9, z); push_st(4'd10, z); end
            6'b000100: push_st(4'd8, z);
            6'b000010: push_st(4'd11, z);
            default: ;
        endcase
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("state(op=%b)", bus.opcode), {28'b0, bus.state_o}, {28'b0, e.st});
            check($sformatf("ctl(st=%0d)", e.st), {18'b0, obs_ctl()}, {18'b0, e.ctl});
            @(negedge clk);
        end
    endtask

    initial begin
        bus.opcode = 6'b000000;
        bus.zero   = 1'b0;
        #12;
        check("rst_state", {28'b0, bus.state_o}, 32'd0);
        check("rst_ctl", {18'b0, obs_ctl()}, {18'b0, exp_ctl(4'd0, 1'b0)});
        @(negedge clk);
        rst = 1'b1;

        drive_instr(6'b100011, 1'b1); drain();
        drive_instr(6'b000100, 1'b1); drain();
        drive_instr(6'b000100, 1'b0); drain();
        drive_instr(6'b101011, 1'b0); drain();
        drive_instr(6'b000000, 1'b1); drain();
        drive_instr(6'b001000, 1'b1); drain();
        drive_instr(6'b000010, 1'b0); drain();
        drive_instr(6'b111111, 1'b1); drain();
        drive_instr(6'b000001, 1'b0); drain();

        // Reset in the middle of a sw, while sitting in MEMWR.
        bus.opcode = 6'b101011;
        bus.zero   = 1'b0;
        push_st(4'd0, 1'b0);
        push_st(4'd1, 1'b0);
        push_st(4'd2, 1'b0);
        drain();
        check("memwr_state", {28'b0, bus.state_o}, 32'd5);
        check("memwr_mw", {31'b0, bus.mem_write}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mw", {31'b0, bus.mem_write}, 32'd0);
        check("rst_mid_state", {28'b0, bus.state_o}, 32'd0);
        check("rst_mid_ctl", {18'b0, obs_ctl()}, {18'b0, exp_ctl(4'd0, 1'b0)});
        @(posedge clk);
        #1;
        check("rst_hold_state", {28'b0, bus.state_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        drive_instr(6'b000000, 1'b0); drain();
        check("final_state", {28'b0, bus.state_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; opcode and state encodings SHALL come from the shared package.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset; when low, the FSM is forced to FETCH regardless of clk.
REQ-004 The block SHALL have port opcode, input, 6 bits: instruction bits [31:26] from the instruction register.
REQ-005 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 The block SHALL have port pc_write, output, 1 bit: PC register enable.
REQ-007 The block SHALL have ports iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg and alu_src_a, each an output of 1 bit: datapath controls.
REQ-008 The block SHALL have ports alu_src_b, alu_op and pc_src, each an output of 2 bits.
REQ-009 The block SHALL have port state_o, output, 4 bits: current state, for debug only.

Function
REQ-010 The block SHALL be a Moore FSM with 4-bit state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-011 The transitions SHALL be: FETCH->DECODE unconditionally; from DECODE, lw/sw->MEMADR, R-type->EXECUTE, beq->BEQEX, addi->ADDIEX, j->JEX, any other opcode->FETCH.
REQ-012 The remaining transitions SHALL be: MEMADR goes to MEMRD for lw and to MEMWR for sw; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BEQEX, ADDIWB and JEX all go to FETCH.
REQ-013 The opcodes SHALL be: R-type=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
REQ-014 The block SHALL compute pc_write combinationally as pc_write_uncond OR (branch AND zero), with branch asserted only in BEQEX.
REQ-015 In FETCH the outputs SHALL be: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, pc_write_uncond=1.
REQ-016 In DECODE the outputs SHALL be: alu_src_a=0, alu_src_b=11, alu_op=00, with no write strobes.
REQ-017 In MEMADR and ADDIEX the outputs SHALL be: alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-018 In MEMRD the outputs SHALL be iord=1; in MEMWR, iord=1 and mem_write=1.
REQ-019 In MEMWB the outputs SHALL be reg_write=1, reg_dst=0, mem_to_reg=1; in ALUWB, reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-020 In ADDIWB the outputs SHALL be reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-021 In EXECUTE the outputs SHALL be alu_src_a=1, alu_src_b=00, alu_op=10.
REQ-022 In BEQEX the outputs SHALL be alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1.
REQ-023 In JEX the outputs SHALL be pc_src=10 and pc_write_uncond=1.
REQ-024 Any output not listed for a state SHALL be 0, with no X propagation.
REQ-025 Illegal state codes 12-15 SHALL transition to FETCH on the next clock and drive all-zero outputs.
REQ-026 Instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; an unsupported opcode 2 cycles.
REQ-027 The zero input SHALL be ignored in every state except BEQEX.

Reset
REQ-028 Asserting rst low SHALL move the state to FETCH immediately, including mid-instruction, and any in-flight write strobe SHALL drop in the same delta.
REQ-029 While rst is low, the outputs SHALL equal the FETCH decode, and state_o SHALL be 0.
REQ-030 After rst deasserts, the first rising edge of clk SHALL move FETCH->DECODE.

Structure
REQ-031 The shared package mips_mc_pkg SHALL hold the state encodings, the opcode constants and the alu_op constants (ADD=00, SUB=01, FUNCT=10).
REQ-032 The state-to-output decode SHALL be a purely combinational sub-module, mc_output_decode.

Verification
REQ-033 Release rst, then opcode=100011 -> states 0,1,2,3,4,0; pc_write=1 only in cycle 0; reg_write=1 with mem_to_reg=1 in state 4.
REQ-034 opcode=000100: zero=1 -> pc_write=1 and pc_src=01 in BEQEX; zero=0 -> pc_write=0 in BEQEX; return to FETCH in both cases.
REQ-035 opcode=101011 -> states 0,1,2,5,0; mem_write=1 and iord=1 in state 5 only.
REQ-036 opcode=111111 -> states 0,1,0; no write strobes in the DECODE cycle.
REQ-037 Assert rst low mid-cycle while in MEMWR -> mem_write falls immediately; state_o=0 before the next clock edge.
REQ-038 opcode=000010 -> states 0,1,11,0; pc_write=1 and pc_src=10 in JEX.
